imem_responder: RTL and testbench

- Multi-cycle instruction-memory responder; the memory-side end of the fetch interface.
- The fetch stage issues a 16-bit PC request. This block accepts it, waits a programmable latency, and returns the 16-bit instruction with a one-cycle valid pulse.
- Its busy/stall indication lets the pipeline freeze the PC.
- A load port preloads program words before or between fetches.

---
 rtl/imem_responder_pkg.sv | 15 +
 rtl/imem_array.sv | 27 ++
 rtl/imem_responder.sv | 142 ++++++++++++++
 tb/tb_imem_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// instruction width and the NOP word returned on a faulting fetch.
package imem_responder_pkg;

  localparam int IMEM_INSTR_W = 16;

  localparam logic [IMEM_INSTR_W-1:0] IMEM_NOP = 16'h0800;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// Program store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [IMEM_INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]       raddr_i,
  output logic [IMEM_INSTR_W-1:0] rdata_o
);

  logic [IMEM_INSTR_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-edge contents, so a same-edge load/fetch returns the old word.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder with programmable fetch latency.
// Define IMEM_ALIGN_CHECK_EN to add rsp_err_o and NOP substitution on bad addresses.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic [15:0]             req_addr_i,
  output logic                    req_ready_o,
  output logic                    rsp_valid_o,
  output logic [IMEM_INSTR_W-1:0] rsp_instr_o,
  output logic                    stall_o,
`ifdef IMEM_ALIGN_CHECK_EN
  output logic                    rsp_err_o,
`endif
  input  logic                    ld_en_i,
  input  logic [15:0]             ld_addr_i,
  input  logic [IMEM_INSTR_W-1:0] ld_data_i
);

  // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o;
  // the response is a single-cycle rsp_valid_o pulse with no back-pressure.

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  imem_state_e             state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IMEM_INSTR_W-1:0] data_q, data_d;
  logic [IMEM_INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
  logic [IMEM_INSTR_W-1:0] rd_word;
  logic [IMEM_INSTR_W-1:0] cap_word;
  logic                    accept;
  logic                    unused_addr_bits;

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .we_i    (ld_en_i),
    .waddr_i (ld_addr_i[ADDR_W:1]),
    .wdata_i (ld_data_i),
    .raddr_i (req_addr_i[ADDR_W:1]),
    .rdata_o (rd_word)
  );

  // Byte-offset and high address bits are truncated away in the default build.
  assign unused_addr_bits = ^{req_addr_i[15:ADDR_W+1], req_addr_i[0],
                              ld_addr_i[15:ADDR_W+1], ld_addr_i[0]};

`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic [15:0] HI_MASK = 16'hFFFF << (ADDR_W + 1);

  logic cap_err;
  logic err_q, err_d;
  logic rsp_err_q, rsp_err_d;

  assign cap_err  = req_addr_i[0] | (|(req_addr_i & HI_MASK));
  assign cap_word = cap_err ? IMEM_NOP : rd_word;
`else
  assign cap_word = rd_word;
`endif

  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rsp_instr_d = rsp_instr_q;
`ifdef IMEM_ALIGN_CHECK_EN
    err_d       = err_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IMEM_IDLE, IMEM_RESP: begin
        if (accept) begin
          cnt_d  = CNT_LOAD;
          data_d = cap_word;
`ifdef IMEM_ALIGN_CHECK_EN
          err_d  = cap_err;
`endif
          if (LATENCY == 1) begin
            state_d     = IMEM_RESP;
            rsp_instr_d = cap_word;
`ifdef IMEM_ALIGN_CHECK_EN
            rsp_err_d   = cap_err;
`endif
          end else begin
            state_d = IMEM_WAIT;
          end
        end else begin
          state_d = IMEM_IDLE;
        end
      end
      IMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = IMEM_RESP;
          rsp_instr_d = data_q;
`ifdef IMEM_ALIGN_CHECK_EN
          rsp_err_d   = err_q;
`endif
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IMEM_IDLE;
      cnt_q       <= 4'd0;
      data_q      <= '0;
      rsp_instr_q <= '0;
`ifdef IMEM_ALIGN_CHECK_EN
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      rsp_instr_q <= rsp_instr_d;
`ifdef IMEM_ALIGN_CHECK_EN
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // rsp_instr_o only updates on entry to RESP, so it holds after the pulse.
  assign req_ready_o = (state_q == IMEM_IDLE) || (state_q == IMEM_RESP);
  assign rsp_valid_o = (state_q == IMEM_RESP);
  assign rsp_instr_o = rsp_instr_q;
  assign stall_o     = (state_q == IMEM_WAIT);
`ifdef IMEM_ALIGN_CHECK_EN
  assign rsp_err_o   = rsp_err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one LATENCY=3 and one LATENCY=1 instance
// share all inputs; each scenario checks the instance it targets.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  logic        ready3, valid3, stall3, err3;
  logic [15:0] instr3;
  logic        ready1, valid1, stall1, err1;
  logic [15:0] instr1;

  int total = 0;
  int bad   = 0;

  imem_responder #(.ADDR_W(8), .LATENCY(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (ready3),
    .rsp_valid_o (valid3),
    .rsp_instr_o (instr3),
    .stall_o     (stall3),
`ifdef IMEM_ALIGN_CHECK_EN
    .rsp_err_o   (err3),
`endif
    .ld_en_i     (ld_en),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data)
  );

  imem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (ready1),
    .rsp_valid_o (valid1),
    .rsp_instr_o (instr1),
    .stall_o     (stall1),
`ifdef IMEM_ALIGN_CHECK_EN
    .rsp_err_o   (err1),
`endif
    .ld_en_i     (ld_en),
    .ld_addr_i   (ld_addr),
    .ld_data_i   (ld_data)
  );

`ifndef IMEM_ALIGN_CHECK_EN
  assign err3 = 1'b0;
  assign err1 = 1'b0;
`endif

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Issue one fetch to the LATENCY=3 instance and wait (bounded) for its pulse.
  task automatic fetch3(input logic [15:0] a, output logic [15:0] instr,
                        output logic err, output int lat);
    req_valid = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!valid3 && lat < 20) begin
      tick();
      lat++;
    end
    instr = instr3;
    err   = err3;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (ready3 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready3); end
    total++; if (stall3 !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall3); end
    total++; if (valid3 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid3); end
    total++; if (instr3 !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instr3); end
    total++; if (ready1 !== 1'b1 || valid1 !== 1'b0) begin bad++; $display("FAIL reset_lat1: got ready=%b valid=%b want 1/0", ready1, valid1); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    load_word(16'h0010, 16'hA5C3);
    req_valid = 1'b1; req_addr = 16'h0010;
    #1;
    total++; if (stall3 !== 1'b0) begin bad++; $display("FAIL basic_stall_pre: got %b want 0", stall3); end
    tick();
    req_valid = 1'b0;
    total++; if (stall3 !== 1'b1 || valid3 !== 1'b0) begin bad++; $display("FAIL basic_e1: got stall=%b valid=%b want 1/0", stall3, valid3); end
    total++; if (ready3 !== 1'b0) begin bad++; $display("FAIL basic_ready_wait: got %b want 0", ready3); end
    tick();
    total++; if (stall3 !== 1'b1 || valid3 !== 1'b0) begin bad++; $display("FAIL basic_e2: got stall=%b valid=%b want 1/0", stall3, valid3); end
    tick();
    total++; if (stall3 !== 1'b0 || valid3 !== 1'b1) begin bad++; $display("FAIL basic_e3: got stall=%b valid=%b want 0/1", stall3, valid3); end
    total++; if (instr3 !== 16'hA5C3) begin bad++; $display("FAIL basic_data: got %h want a5c3", instr3); end
    total++; if (err3 !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err3); end
    tick();
    total++; if (valid3 !== 1'b0 || instr3 !== 16'hA5C3) begin bad++; $display("FAIL basic_hold: got valid=%b instr=%h want 0/a5c3", valid3, instr3); end
    total++; if (ready3 !== 1'b1) begin bad++; $display("FAIL basic_ready_after: got %b want 1", ready3); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_addr = 16'h0010;
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (stall3 !== 1'b1) begin bad++; $display("FAIL rmw_stall_before: got %b want 1", stall3); end
    rst = 1'b1;
    #1;
    total++; if (ready3 !== 1'b1 || stall3 !== 1'b0) begin bad++; $display("FAIL rmw_ready_stall: got ready=%b stall=%b want 1/0", ready3, stall3); end
    total++; if (valid3 !== 1'b0 || instr3 !== 16'h0000) begin bad++; $display("FAIL rmw_rsp: got valid=%b instr=%h want 0/0000", valid3, instr3); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (valid3 !== 1'b0) begin bad++; $display("FAIL rmw_no_pulse: got %b want 0 (cycle %0d)", valid3, i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q [$];
    load_word(16'h0000, 16'h0001);
    load_word(16'h0002, 16'h0002);
    load_word(16'h0004, 16'h0003);
    exp_q = '{16'h0001, 16'h0002, 16'h0003};
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 16'(2 * i);
      tick();
      total++; if (valid1 !== 1'b1 || instr1 !== exp_q[0]) begin bad++; $display("FAIL b2b_rsp%0d: got valid=%b instr=%h want 1/%h", i, valid1, instr1, exp_q[0]); end
      total++; if (stall1 !== 1'b0 || ready1 !== 1'b1) begin bad++; $display("FAIL b2b_flow%0d: got stall=%b ready=%b want 0/1", i, stall1, ready1); end
      void'(exp_q.pop_front());
    end
    req_valid = 1'b0;
    tick();
    total++; if (valid1 !== 1'b0 || instr1 !== 16'h0003) begin bad++; $display("FAIL b2b_end: got valid=%b instr=%h want 0/0003", valid1, instr1); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_load_collision();
    logic [15:0] got;
    logic        err;
    int          lat;
    load_word(16'h0008, 16'h1111);
    req_valid = 1'b1; req_addr = 16'h0008;
    ld_en = 1'b1; ld_addr = 16'h0008; ld_data = 16'h2222;
    tick();
    req_valid = 1'b0; ld_en = 1'b0;
    lat = 1;
    while (!valid3 && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL coll_latency: got %0d want 3", lat); end
    total++; if (instr3 !== 16'h1111) begin bad++; $display("FAIL coll_old: got %h want 1111", instr3); end
    tick();
    fetch3(16'h0008, got, err, lat);
    total++; if (got !== 16'h2222) begin bad++; $display("FAIL coll_new: got %h want 2222", got); end
    // A load landing while the fetch is in flight must not alter it.
    req_valid = 1'b1; req_addr = 16'h0008;
    tick();
    req_valid = 1'b0;
    load_word(16'h0008, 16'h3333);
    tick();
    total++; if (valid3 !== 1'b1 || instr3 !== 16'h2222) begin bad++; $display("FAIL inflight_load: got valid=%b instr=%h want 1/2222", valid3, instr3); end
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    logic        err;
    int          lat;
    load_word(16'h0002, 16'hBEEF);
    fetch3(16'h0202, got, err, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL wrap_latency: got %0d want 3", lat); end
`ifdef IMEM_ALIGN_CHECK_EN
    total++; if (err !== 1'b1 || got !== 16'h0800) begin bad++; $display("FAIL wrap_err: got err=%b instr=%h want 1/0800", err, got); end
`else
    total++; if (got !== 16'hBEEF) begin bad++; $display("FAIL wrap_data: got %h want beef", got); end
`endif
  endtask

  task automatic test_misaligned();
    logic [15:0] got;
    logic        err;
    int          lat;
    fetch3(16'h0003, got, err, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL mis_latency: got %0d want 3", lat); end
`ifdef IMEM_ALIGN_CHECK_EN
    total++; if (err !== 1'b1 || got !== 16'h0800) begin bad++; $display("FAIL mis_err: got err=%b instr=%h want 1/0800", err, got); end
`else
    total++; if (got !== 16'hBEEF) begin bad++; $display("FAIL mis_trunc: got %h want beef", got); end
`endif
    fetch3(16'h0002, got, err, lat);
    total++; if (err !== 1'b0 || got !== 16'hBEEF) begin bad++; $display("FAIL aligned_after: got err=%b instr=%h want 0/beef", err, got); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 16'h0000;
    ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 16'h0000;
    test_reset();
    test_basic_fetch();
    test_reset_mid_wait();
    test_back_to_back();
    test_load_collision();
    test_wrap();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
